snn_frame_sched: RTL and testbench

SNN_FRAME_SCHED -- requirements
Module: snn_frame_sched

---
 rtl/snn_pkg.sv | 21 ++
 rtl/snn_byte_unpack.sv | 82 ++++++++
 rtl/snn_frame_sched.sv | 151 +++++++++++++++
 tb/tb_snn_frame_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snn_pkg
// Brief    : Shared types and constants for the SNN frame scheduler.
// Revision : 1.0
// ============================================================================
package snn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UNPACK  = 3'd1,
        ST_CORE    = 3'd2,
        ST_TX_REQ  = 3'd3,
        ST_TX_WAIT = 3'd4
    } state_t;

    localparam int         PIXELS_PER_FRAME = 784;
    localparam logic [7:0] ASCII_ZERO       = 8'h30;

endpackage
`default_nettype wire

// File: rtl/snn_byte_unpack.sv
`default_nettype none
// ============================================================================
// Module   : snn_byte_unpack
// Brief    : Byte shift register, one-deep pending slot, bit counter, overrun.
// Revision : 1.0
// ============================================================================
module snn_byte_unpack
    import snn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  state_t     i_state,
    input  logic       i_rx_rdy,
    input  logic [7:0] i_rx_data,
    input  logic       i_frame_end,
    output logic       o_bit,
    output logic [2:0] o_bit_idx,
    output logic       o_byte_done,
    output logic       o_chain,
    output logic       o_overrun
);

    logic [7:0] r_shift;
    logic [7:0] r_pend;
    logic       r_pend_vld;
    logic [2:0] r_bit_idx;
    logic       r_overrun;

    assign o_bit       = r_shift[0];
    assign o_bit_idx   = r_bit_idx;
    assign o_byte_done = (i_state == ST_UNPACK) && (r_bit_idx == 3'd7);
    assign o_chain     = r_pend_vld || i_rx_rdy;
    assign o_overrun   = r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= 8'h00;
            r_pend     <= 8'h00;
            r_pend_vld <= 1'b0;
            r_bit_idx  <= 3'd0;
            r_overrun  <= 1'b0;
        end else begin
            case (i_state)
                ST_IDLE: begin
                    if (i_rx_rdy) begin
                        r_shift   <= i_rx_data;
                        r_bit_idx <= 3'd0;
                    end
                end
                ST_UNPACK: begin
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_bit_idx <= r_bit_idx + 3'd1;
                    if (i_frame_end) begin
                        r_pend_vld <= 1'b0;
                        if (r_pend_vld || i_rx_rdy) r_overrun <= 1'b1;
                    end else if (o_byte_done) begin
                        // Slot frees on the last bit, so a byte arriving now is still kept
                        if (r_pend_vld) begin
                            r_shift    <= r_pend;
                            r_pend     <= i_rx_data;
                            r_pend_vld <= i_rx_rdy;
                        end else if (i_rx_rdy) begin
                            r_shift <= i_rx_data;
                        end
                    end else if (i_rx_rdy) begin
                        if (r_pend_vld) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_pend     <= i_rx_data;
                            r_pend_vld <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (i_rx_rdy) r_overrun <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/snn_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : snn_frame_sched
// Brief    : UART frame loader -> pixel RAM -> inference core -> ASCII result.
// Options  : SNN_RX_TIMEOUT_EN enables the inter-byte partial-frame timeout.
// Revision : 1.0
// ============================================================================
module snn_frame_sched
    import snn_pkg::*;
#(
    parameter int BYTES_PER_FRAME = 98,
    parameter int TIMEOUT_CYC     = 2_500_000
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       ram_we,
    output logic [9:0] ram_addr,
    output logic       ram_wdata,
    input  logic [9:0] core_addr,
    output logic       core_start,
    input  logic       core_done,
    input  logic [3:0] core_digit,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_rdy,
    output logic [7:0] led,
    output logic       busy,
    output logic       overrun,
    output logic       rx_timeout
);

    localparam int                    c_BYTE_W    = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
    localparam logic [c_BYTE_W-1:0]   c_LAST_BYTE = c_BYTE_W'(BYTES_PER_FRAME - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_BYTE_W-1:0] r_byte_cnt;
    logic [3:0]          r_digit;
    logic [7:0]          r_tx_data;
    logic                r_core_start;
    logic                r_wait_first;
    logic                w_bit;
    logic [2:0]          w_bit_idx;
    logic                w_byte_done;
    logic                w_chain;
    logic                w_frame_end;
    logic                w_timeout;
    logic                w_tx_start;
    logic [9:0]          w_load_addr;

    assign w_frame_end = w_byte_done && (r_byte_cnt == c_LAST_BYTE);
    assign w_load_addr = 10'({r_byte_cnt, w_bit_idx});

    snn_byte_unpack u_unpack (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_state     (r_state),
        .i_rx_rdy    (rx_rdy),
        .i_rx_data   (rx_data),
        .i_frame_end (w_frame_end),
        .o_bit       (w_bit),
        .o_bit_idx   (w_bit_idx),
        .o_byte_done (w_byte_done),
        .o_chain     (w_chain),
        .o_overrun   (overrun)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tx_start  = 1'b0;
        case (r_state)
            ST_IDLE:    if (rx_rdy) w_state_nxt = ST_UNPACK;
            ST_UNPACK: begin
                if (w_frame_end)      w_state_nxt = ST_CORE;
                else if (w_byte_done) w_state_nxt = w_chain ? ST_UNPACK : ST_IDLE;
            end
            ST_CORE:    if (core_done) w_state_nxt = ST_TX_REQ;
            ST_TX_REQ: begin
                if (tx_rdy) begin
                    w_tx_start  = 1'b1;
                    w_state_nxt = ST_TX_WAIT;
                end
            end
            // Transmitter has not yet dropped tx_rdy in the cycle after tx_start
            ST_TX_WAIT: if (!r_wait_first && tx_rdy) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= '0;
            r_digit      <= 4'd0;
            r_tx_data    <= 8'h00;
            r_core_start <= 1'b0;
            r_wait_first <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_core_start <= w_frame_end;
            r_wait_first <= w_tx_start;
            if (w_timeout || w_frame_end) r_byte_cnt <= '0;
            else if (w_byte_done)         r_byte_cnt <= r_byte_cnt + c_BYTE_W'(1);
            if (r_state == ST_CORE && core_done) begin
                r_digit   <= core_digit;
                r_tx_data <= ASCII_ZERO + {4'd0, core_digit};
            end
        end
    end

`ifdef SNN_RX_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_TO_W-1:0] r_idle_cnt;
    logic              r_rx_timeout;

    assign w_timeout  = (r_state == ST_IDLE) && (r_byte_cnt != '0) && !rx_rdy &&
                        (r_idle_cnt == c_TO_W'(TIMEOUT_CYC - 1));
    assign rx_timeout = r_rx_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt   <= '0;
            r_rx_timeout <= 1'b0;
        end else begin
            r_rx_timeout <= w_timeout;
            if (r_state != ST_IDLE || rx_rdy || w_timeout || r_byte_cnt == '0) r_idle_cnt <= '0;
            else                                                                r_idle_cnt <= r_idle_cnt + c_TO_W'(1);
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign rx_timeout       = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
`endif

    assign ram_we     = (r_state == ST_UNPACK);
    assign ram_addr   = (r_state == ST_UNPACK) ? w_load_addr : core_addr;
    assign ram_wdata  = (r_state == ST_UNPACK) && w_bit;
    assign core_start = r_core_start;
    assign tx_start   = w_tx_start;
    assign tx_data    = r_tx_data;
    assign led        = {4'd0, r_digit};
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_snn_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_frame_sched
// Brief    : Randomized self-checking bench with a cycle-level schedule model.
// Revision : 1.0
// ============================================================================
module tb_snn_frame_sched;

    localparam int BPF    = 98;
    localparam int TO_CYC = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [9:0] core_addr = 10'd0;
    logic       core_done = 1'b0;
    logic [3:0] core_digit = 4'd0;
    logic       tx_rdy = 1'b0;
    logic       ram_we, ram_wdata, core_start, tx_start, busy, overrun, rx_timeout;
    logic [9:0] ram_addr;
    logic [7:0] tx_data, led;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    snn_frame_sched #(.BYTES_PER_FRAME(BPF), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .core_addr(core_addr), .core_start(core_start), .core_done(core_done),
        .core_digit(core_digit), .tx_start(tx_start), .tx_data(tx_data),
        .tx_rdy(tx_rdy), .led(led), .busy(busy), .overrun(overrun),
        .rx_timeout(rx_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: each accepted byte owns 8 consecutive write cycles.
    typedef struct {
        int cyc;
        int addr;
        bit d;
    } wr_t;

    wr_t  exp_wr[$];
    int   exp_cs[$];
    int   last_start = -100;
    int   last_end = -100;
    int   last_core_cyc = 0;
    int   nbytes = 0;
    bit   frame_full = 0;
    bit   exp_ovr = 0;
    logic [3:0] prev_dig = 4'd0;
    logic [7:0] prev_tx = 8'h00;

    function automatic void model_rx(input int t, input logic [7:0] d);
        int s;
`ifdef SNN_RX_TIMEOUT_EN
        if (!frame_full && nbytes > 0 && t > last_end + TO_CYC) nbytes = 0;
`endif
        if (frame_full || last_start > t + 1) begin
            exp_ovr = 1;
            return;
        end
        s = (t + 1 > last_end + 1) ? t + 1 : last_end + 1;
        for (int b = 0; b < 8; b++) exp_wr.push_back('{s + b, nbytes * 8 + b, d[b]});
        last_start = s;
        last_end   = s + 7;
        nbytes++;
        if (nbytes == BPF) begin
            frame_full    = 1;
            nbytes        = 0;
            last_core_cyc = last_end + 1;
            exp_cs.push_back(last_core_cyc);
        end
    endfunction

    function automatic void model_clear();
        exp_wr.delete();
        exp_cs.delete();
        last_start = -100;
        last_end   = -100;
        nbytes     = 0;
        frame_full = 0;
        exp_ovr    = 0;
        prev_dig   = 4'd0;
        prev_tx    = 8'h00;
    endfunction

    // Monitor
    bit  img [0:1023];
    int  n_wr = 0, n_cs = 0, n_txs = 0, n_to = 0;
    int  last_txs_cyc = -1, last_to_cyc = -1;
    wr_t mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we) begin
                n_wr++;
                img[ram_addr] = ram_wdata;
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 64'(ram_addr), 64'h3ff_0000);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("wr", {32'(cyc), 21'd0, ram_addr, ram_wdata},
                          {32'(mon_e.cyc), 21'd0, 10'(mon_e.addr), mon_e.d});
                end
            end else begin
                check("ram_addr_mux", 64'(ram_addr), 64'(core_addr));
            end
            if (core_start) begin
                n_cs++;
                if (exp_cs.size() == 0) check("core_start_unexpected", 64'(cyc), 64'hffff_ffff);
                else                    check("core_start_cyc", 64'(cyc), 64'(exp_cs.pop_front()));
            end
            if (tx_start) begin
                n_txs++;
                last_txs_cyc = cyc;
            end
            if (rx_timeout) begin
                n_to++;
                last_to_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        core_addr = 10'($urandom_range(0, 1023));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] d);
        rx_rdy  = 1'b1;
        rx_data = d;
        model_rx(cyc, d);
        step();
        rx_rdy  = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_core_start", 64'(core_start), 64'd0);
        check("rst_tx_start", 64'(tx_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_rx_timeout", 64'(rx_timeout), 64'd0);
        check("rst_led", 64'(led), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        check_reset_outputs();
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    // mode 0: 8'hA5 every 100 cycles; mode 1: random bytes, bursty gaps, stray core_done
    task automatic send_frame(input int mode);
        int g;
        while (!frame_full) begin
            send(mode == 0 ? 8'hA5 : 8'($urandom));
            if (mode == 0) begin
                idle(99);
            end else begin
                g = $urandom_range(0, 12);
                repeat (g) begin
                    if ($urandom_range(0, 15) == 0) begin
                        core_done  = 1'b1;
                        core_digit = 4'($urandom_range(0, 9));
                    end
                    step();
                    core_done = 1'b0;
                end
            end
        end
    endtask

    task automatic do_result(input logic [3:0] dig, input int d, input int k, input bit rx_in_core);
        int x, y, cs0, txs0;
        check("led_hold", 64'(led), 64'({4'd0, prev_dig}));
        check("tx_data_hold", 64'(tx_data), 64'(prev_tx));
        txs0 = n_txs;
        while (cyc < last_core_cyc) step();
        idle($urandom_range(1, 4));
        if (rx_in_core) begin
            cs0 = n_cs;
            send(8'($urandom));
            @(negedge clk);
            check("overrun_in_core", 64'(overrun), 64'd1);
            check("core_start_count_core_rx", 64'(n_cs), 64'(cs0));
        end
        core_done  = 1'b1;
        core_digit = dig;
        tx_rdy     = (d == 0);
        step();
        core_done  = 1'b0;
        core_digit = 4'($urandom_range(0, 15));
        @(negedge clk);
        check("led_result", 64'(led), 64'({4'd0, dig}));
        check("tx_data_ascii", 64'(tx_data), 64'(8'h30 + {4'd0, dig}));
        if (d > 0) begin
            idle(d);
            tx_rdy = 1'b1;
        end
        x = cyc;
        step();
        @(negedge clk);
        check("busy_tx_wait_first", 64'(busy), 64'd1);
        check("tx_start_count", 64'(n_txs - txs0), 64'd1);
        check("tx_start_cyc", 64'(last_txs_cyc), 64'(x));
        for (int i = 0; i < k; i++) begin
            step();
            tx_rdy = 1'b0;
        end
        step();
        tx_rdy = 1'b1;
        y = cyc;
        @(negedge clk);
        check("busy_before_idle", 64'(busy), 64'd1);
        step();
        @(negedge clk);
        check("busy_idle", 64'(busy), 64'd0);
        check("idle_cyc", 64'(cyc), 64'(y + 1));
        frame_full = 0;
        prev_dig   = dig;
        prev_tx    = 8'h30 + {4'd0, dig};
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int wr0, cs0, to0, le;
        rst_n = 1'b0;
        idle(2);
        check_reset_outputs();
        check("rst_ram_addr_mux", 64'(ram_addr), 64'(core_addr));
        rst_n = 1'b1;
        idle(2);

        // Fixed A5 frame, then digit 7 with tx_rdy held high and a byte during CORE
        wr0 = n_wr;
        cs0 = n_cs;
        send_frame(0);
        while (cyc < last_core_cyc) step();
        @(negedge clk);
        check("a5_write_count", 64'(n_wr - wr0), 64'(784));
        check("a5_core_starts", 64'(n_cs - cs0), 64'd1);
        check("a5_addr0", 64'(img[0]), 64'd1);
        check("a5_addr1", 64'(img[1]), 64'd0);
        check("a5_addr783", 64'(img[783]), 64'd1);
        check("a5_overrun", 64'(overrun), 64'd0);
        do_result(4'd7, 0, 0, 1'b1);

        // Randomized bursty frames
        repeat (3) begin
            send_frame(1);
            do_result(4'($urandom_range(0, 9)), $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
            check("overrun_random", 64'(overrun), 64'(exp_ovr));
        end

        // Back-to-back bytes into the pending slot, then a third in the same window
        do_reset();
        send(8'($urandom));
        idle(1);
        send(8'($urandom));
        @(negedge clk);
        check("pending_no_overrun", 64'(overrun), 64'd0);
        send(8'($urandom));
        @(negedge clk);
        check("pending_overrun", 64'(overrun), 64'd1);
        send_frame(1);
        do_result(4'($urandom_range(0, 9)), 1, 2, 1'b0);

        // Reset while unpacking byte 50
        do_reset();
        while (nbytes < 51) begin
            send(8'($urandom));
            idle(9);
        end
        idle(3);
        wr0 = n_wr;
        rst_n = 1'b0;
        model_clear();
        check_reset_outputs();
        idle(2);
        rst_n = 1'b1;
        idle(3);
        check("writes_during_reset", 64'(n_wr - wr0), 64'd0);
        send_frame(1);
        do_result(4'($urandom_range(0, 9)), 0, 1, 1'b0);

        // Partial frame left idle
        to0 = n_to;
        repeat (10) begin
            send(8'($urandom));
            idle(19);
        end
        le = last_end;
        idle(TO_CYC + 100);
`ifdef SNN_RX_TIMEOUT_EN
        check("timeout_pulses", 64'(n_to - to0), 64'd1);
        check("timeout_cyc", 64'(last_to_cyc), 64'(le + TO_CYC + 1));
`else
        check("timeout_pulses", 64'(n_to - to0), 64'd0);
`endif
        send(8'($urandom));
        idle(12);
        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        check("cs_queue_drained", 64'(exp_cs.size()), 64'd0);
        check("overrun_final", 64'(overrun), 64'(exp_ovr));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
